sram_burst_counter: RTL and testbench

Parametrised burst address generator for the SRAM datapath. It replaces the fixed 7-bit, free-running SRAM counter with a counter that has:
- configurable width, base address and wrap point;
- a burst length with start/done handshaking;
- selectable wrap or saturate behaviour at the wrap point.

The SRAM controller FSM issues a start with a base address and beat count, then steps the counter once per accepted SRAM beat until done.

---
 rtl/sram_burst_counter.sv | 106 ++++++++++
 tb/tb_sram_burst_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_counter.sv
// Burst address generator for the SRAM datapath: loads a base address and beat
// count on start, steps once per accepted beat, wraps or saturates at rollover_val.
module sram_burst_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH:0]   burst_len,
  input  logic [WIDTH-1:0] rollover_val,
  input  logic             sat_mode,
  input  logic             cnt_enable,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH:0]   beats_left,
  output logic             rollover_flag,
  output logic             wrap_pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   beats_q, beats_d;
  logic             wrap_q, wrap_d;
  logic             flag_q;
  logic             busy_q, done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    beats_d = beats_q;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      beats_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d = base_addr;
            beats_d = burst_len;
            state_d = (burst_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_enable) begin
            beats_d = beats_q - 1'b1;
            if (count_q == rollover_val) begin
              // Saturate leaves count_d at its held value.
              if (!sat_mode) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
            if (beats_q == {{WIDTH{1'b0}}, 1'b1}) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      beats_q <= '0;
      wrap_q  <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      beats_q <= beats_d;
      wrap_q  <= wrap_d;
      flag_q  <= (count_d == rollover_val);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign count_out     = count_q;
  assign beats_left    = beats_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = wrap_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sram_burst_counter.sv
// Self-checking bench for sram_burst_counter: closed-form burst model checked
// every cycle, plus directed literal expectations per scenario.
module tb_sram_burst_counter;
  localparam int WIDTH = 7;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] base_addr = '0;
  logic [WIDTH:0]   burst_len = '0;
  logic [WIDTH-1:0] rollover_val = 7'd127;
  logic             sat_mode = 1'b0;
  logic             cnt_enable = 1'b0;
  logic [WIDTH-1:0] count_out;
  logic [WIDTH:0]   beats_left;
  logic             rollover_flag, wrap_pulse, busy, done;

  int n_total = 0;
  int n_pass  = 0;

  sram_burst_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .base_addr(base_addr), .burst_len(burst_len), .rollover_val(rollover_val),
    .sat_mode(sat_mode), .cnt_enable(cnt_enable), .count_out(count_out),
    .beats_left(beats_left), .rollover_flag(rollover_flag),
    .wrap_pulse(wrap_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Steps needed from base to first reach rv, counting the natural overflow.
  function automatic int dist_to_rv(int base, int rv);
    return (rv - base + MOD) % MOD;
  endfunction

  // Address after n accepted beats of a burst starting at base.
  function automatic int exp_addr(int base, int n, int rv, bit sat);
    int d = dist_to_rv(base, rv);
    if (n <= d) return (base + n) % MOD;
    if (sat) return rv;
    return (n - d - 1) % (rv + 1);
  endfunction

  // True when the n-th beat is a step from rv back to 0.
  function automatic bit wrap_at(int base, int n, int rv, bit sat);
    int d = dist_to_rv(base, rv);
    return !sat && (n > d) && (((n - d - 1) % (rv + 1)) == 0);
  endfunction

  // Burst-level model: phase 0 idle, 1 running, 2 done.
  int m_phase = 0, m_base = 0, m_len = 0, m_n = 0, m_addr = 0;
  bit m_wrap = 0, m_flag = 0;

  initial forever begin
    @(posedge clk);
    m_wrap = 0;
    if (rst) begin
      m_phase = 0; m_base = 0; m_len = 0; m_n = 0; m_addr = 0; m_flag = 0;
    end else begin
      if (clear) begin
        m_phase = 0; m_base = 0; m_len = 0; m_n = 0; m_addr = 0;
      end else if (m_phase == 0) begin
        if (start) begin
          m_base = int'(base_addr); m_len = int'(burst_len); m_n = 0; m_addr = m_base;
          m_phase = (m_len == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (cnt_enable) begin
          m_n++;
          m_wrap = wrap_at(m_base, m_n, int'(rollover_val), sat_mode);
          m_addr = exp_addr(m_base, m_n, int'(rollover_val), sat_mode);
          if (m_n == m_len) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      m_flag = (m_addr == int'(rollover_val));
    end
    #1;
    chk("mdl_count", count_out, m_addr);
    chk("mdl_beats", beats_left, m_len - m_n);
    chk("mdl_flag", rollover_flag, m_flag);
    chk("mdl_wrap", wrap_pulse, m_wrap);
    chk("mdl_busy", busy, m_phase != 0);
    chk("mdl_done", done, m_phase == 2);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_burst(input int b, input int len);
    base_addr = WIDTH'(b); burst_len = (WIDTH+1)'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int w_cnt[5]  = '{126, 127, 0, 1, 2};
    int w_flag[5] = '{0, 1, 0, 0, 0};
    int w_wrap[5] = '{0, 0, 1, 0, 0};
    int o_cnt[6]  = '{125, 126, 127, 0, 1, 2};

    tick(); tick();
    chk("rst_count", count_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Basic burst
    cnt_enable = 1'b1;
    start_burst(10, 4);
    for (int i = 0; i < 5; i++) begin
      chk("basic_count", count_out, 10 + i);
      chk("basic_beats", beats_left, 4 - i);
      chk("basic_done", done, i == 4);
      tick();
    end
    chk("basic_idle", busy, 0);

    // Wrap mode
    start_burst(126, 4);
    for (int i = 0; i < 5; i++) begin
      chk("wrap_count", count_out, w_cnt[i]);
      chk("wrap_flag", rollover_flag, w_flag[i]);
      chk("wrap_pulse", wrap_pulse, w_wrap[i]);
      tick();
    end

    // Natural overflow above rollover_val gives no wrap pulse
    rollover_val = 7'd3;
    start_burst(125, 5);
    for (int i = 0; i < 6; i++) begin
      chk("ovf_count", count_out, o_cnt[i]);
      chk("ovf_wrap", wrap_pulse, 0);
      tick();
    end
    tick();

    // Saturate with stalls
    rollover_val = 7'd63; sat_mode = 1'b1; cnt_enable = 1'b0;
    start_burst(62, 4);
    chk("sat_first", count_out, 62);
    for (int i = 0; i < 7; i++) begin
      cnt_enable = (i % 2 == 0);
      tick();
      chk("sat_count", count_out, 63);
      chk("sat_wrap", wrap_pulse, 0);
      chk("sat_done", done, i == 6);
    end
    cnt_enable = 1'b0; sat_mode = 1'b0; rollover_val = 7'd127;
    tick();

    // Zero-length burst
    start_burst(33, 0);
    chk("zero_done", done, 1);
    chk("zero_count", count_out, 33);
    tick();
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);

    // Start during RUN and DONE is ignored
    start_burst(40, 3);
    base_addr = 7'd99; burst_len = 8'd7; start = 1'b1;
    tick();
    chk("ign_run_count", count_out, 40);
    chk("ign_run_beats", beats_left, 3);
    cnt_enable = 1'b1;
    tick(); tick(); tick();
    chk("ign_done", done, 1);
    chk("ign_done_count", count_out, 43);
    tick();
    chk("ign_idle_count", count_out, 43);
    chk("ign_idle_busy", busy, 0);
    start = 1'b0;
    tick();

    // Clear mid-burst
    start_burst(50, 6);
    tick();
    chk("clr_pre", count_out, 51);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", count_out, 0);
    chk("clr_busy", busy, 0);
    chk("clr_beats", beats_left, 0);
    tick();
    chk("clr_nodone", done, 0);

    // Reset mid-RUN for two cycles, then restart
    start_burst(20, 10);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("rst2_count", count_out, 0);
    chk("rst2_beats", beats_left, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_wrap", wrap_pulse, 0);
    chk("rst2_flag", rollover_flag, 0);
    rst = 1'b0;
    start_burst(5, 2);
    chk("rst2_restart", count_out, 5);
    chk("rst2_rbusy", busy, 1);
    tick(); tick(); tick();
    cnt_enable = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
